// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM bus-cycle controller.
// Optional feature macro used by the design: SRAM_ONEHOT_CHECK_EN.
package sram_ctrl_pkg;

  localparam int NUM_BLOCKS          = 4;
  localparam int DEFAULT_WAIT_STATES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  function automatic logic is_onehot(input logic [NUM_BLOCKS-1:0] v);
    return (v != '0) && ((v & (v - NUM_BLOCKS'(1))) == '0);
  endfunction

endpackage

// File: rtl/sram_bus_cycle_controller_if.sv
// 68000-side strobes and SRAM pin bundle, plus the controller state for observation.
// BusErr_L exists only when SRAM_ONEHOT_CHECK_EN is defined.
interface sram_bus_cycle_controller_if;

  logic                                 AS_L;
  logic                                 RW;
  logic                                 UDS_L;
  logic                                 LDS_L;
  logic                                 SRamSelect_H;
  logic [sram_ctrl_pkg::NUM_BLOCKS-1:0] Block_H;

  logic [sram_ctrl_pkg::NUM_BLOCKS-1:0] SRam_CE_L;
  logic                                 SRam_OE_L;
  logic                                 SRam_WE_L;
  logic                                 SRam_UB_L;
  logic                                 SRam_LB_L;
  logic                                 Dtack_L;
  logic                                 Busy_H;
`ifdef SRAM_ONEHOT_CHECK_EN
  logic                                 BusErr_L;
`endif
  sram_ctrl_pkg::state_e                State;

  // Handshake: a cycle is requested while AS_L is low with SRamSelect_H high and a
  // non-zero Block_H; Dtack_L low acknowledges it, and the cycle ends only once AS_L
  // is seen high, so one AS_L assertion never produces more than one acknowledge.
  modport master (
    output AS_L, RW, UDS_L, LDS_L, SRamSelect_H, Block_H,
    input  SRam_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, Dtack_L, Busy_H,
`ifdef SRAM_ONEHOT_CHECK_EN
    input  BusErr_L,
`endif
    input  State
  );

  modport slave (
    input  AS_L, RW, UDS_L, LDS_L, SRamSelect_H, Block_H,
    output SRam_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, Dtack_L, Busy_H,
`ifdef SRAM_ONEHOT_CHECK_EN
    output BusErr_L,
`endif
    output State
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with a zero flag; paces the ACCESS phase.
module sram_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_H,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_bus_cycle_controller.sv
// One 68000 asynchronous bus cycle against four SRAM blocks with programmable waits.
// Optional SRAM_ONEHOT_CHECK_EN: non-one-hot block selects raise BusErr_L instead of a cycle.
module sram_bus_cycle_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int CNT_W       = 4
) (
  input  logic                         Clk,
  input  logic                         Reset_H,
  sram_bus_cycle_controller_if.slave   bus
);

  if (WAIT_STATES < 0 || WAIT_STATES >= (1 << CNT_W)) begin : g_bad_wait
    $error("WAIT_STATES does not fit in CNT_W bits");
  end

  state_e                r_state, w_next;
  logic [NUM_BLOCKS-1:0] r_blk;
  logic                  r_rw, r_uds, r_lds;
  logic                  w_start, w_abort, w_cnt_load, w_cnt_dec, w_cnt_zero, w_err_start;
  logic                  r_err;

  logic [NUM_BLOCKS-1:0] r_ce, w_ce;
  logic                  r_oe, r_we, r_ub, r_lb, r_dtack, r_busy, r_berr;
  logic                  w_oe, w_we, w_ub, w_lb, w_dtack, w_busy, w_berr;

  assign w_start = !bus.AS_L && bus.SRamSelect_H && (bus.Block_H != '0);

  sram_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .Clk        (Clk),
    .Reset_H    (Reset_H),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(WAIT_STATES)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_abort     = 1'b0;
    w_err_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
`ifdef SRAM_ONEHOT_CHECK_EN
          if (!is_onehot(bus.Block_H)) begin
            w_err_start = 1'b1;
            w_next      = ST_ACK;
          end else begin
            w_next = ST_SETUP;
          end
`else
          w_next = ST_SETUP;
`endif
        end
      end
      ST_SETUP: begin
        if (bus.AS_L) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else begin
          w_cnt_load = 1'b1;
          w_next     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.AS_L) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (w_cnt_zero) begin
          w_next = ST_ACK;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_ACK: begin
        if (bus.AS_L) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request attributes are frozen at the IDLE exit; later bus changes are ignored.
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      r_blk <= '0;
      r_rw  <= 1'b1;
      r_uds <= 1'b1;
      r_lds <= 1'b1;
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_start) begin
      r_blk <= bus.Block_H;
      r_rw  <= bus.RW;
      r_uds <= bus.UDS_L;
      r_lds <= bus.LDS_L;
      r_err <= w_err_start;
    end
  end

  // Pin values follow the current state one edge later; an abort clears them at once.
  always_comb begin
    w_ce    = '1;
    w_oe    = 1'b1;
    w_we    = 1'b1;
    w_ub    = 1'b1;
    w_lb    = 1'b1;
    w_dtack = 1'b1;
    w_berr  = 1'b1;
    w_busy  = (r_state != ST_IDLE) && !w_abort;
    if ((r_state != ST_IDLE) && !w_abort) begin
      w_ce = ~r_blk;
      w_oe = r_rw ? 1'b0 : 1'b1;
      w_ub = r_uds;
      w_lb = r_lds;
      if (r_state == ST_ACCESS) w_we = r_rw;
      if (r_state == ST_ACK)    w_dtack = 1'b0;
      if ((r_state == ST_ACK) && r_err) begin
        w_ce    = '1;
        w_oe    = 1'b1;
        w_ub    = 1'b1;
        w_lb    = 1'b1;
        w_dtack = 1'b1;
        w_berr  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      r_ce    <= '1;
      r_oe    <= 1'b1;
      r_we    <= 1'b1;
      r_ub    <= 1'b1;
      r_lb    <= 1'b1;
      r_dtack <= 1'b1;
      r_busy  <= 1'b0;
      r_berr  <= 1'b1;
    end else begin
      r_ce    <= w_ce;
      r_oe    <= w_oe;
      r_we    <= w_we;
      r_ub    <= w_ub;
      r_lb    <= w_lb;
      r_dtack <= w_dtack;
      r_busy  <= w_busy;
      r_berr  <= w_berr;
    end
  end

  assign bus.SRam_CE_L = r_ce;
  assign bus.SRam_OE_L = r_oe;
  assign bus.SRam_WE_L = r_we;
  assign bus.SRam_UB_L = r_ub;
  assign bus.SRam_LB_L = r_lb;
  assign bus.Dtack_L   = r_dtack;
  assign bus.Busy_H    = r_busy;
  assign bus.State     = r_state;
`ifdef SRAM_ONEHOT_CHECK_EN
  assign bus.BusErr_L  = r_berr;
`else
  logic w_unused_berr;
  assign w_unused_berr = r_berr ^ r_err;
`endif

endmodule

// File: doc/sram_bus_cycle_controller.md
Name: sram_bus_cycle_controller

Overview:
- Downstream consumer of the SRAM block decoder outputs (Block0_H..Block3_H, carried here as a 4-bit vector).
- Runs one 68000 asynchronous bus cycle against four 128K-addressed SRAM blocks:
  - latches block select and strobes,
  - drives per-block chip enables, OE, WE and byte lanes,
  - inserts programmable wait states,
  - returns Dtack_L.
- Sits between the CPU bus interface / SRAM decoder and the SRAM device pins.

Parameters:
- WAIT_STATES, 2, extra ACCESS cycles before DTACK. Range 0..15.
- CNT_W, 4, width of the wait-state counter. WAIT_STATES must fit in CNT_W bits.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_H  in  1  asynchronous, active-high reset.
- AS_L  in  1  68000 address strobe, synchronous to Clk.
- RW  in  1  1=read, 0=write.
- UDS_L  in  1  upper data strobe.
- LDS_L  in  1  lower data strobe.
- SRamSelect_H  in  1  SRAM region select from the address decoder.
- Block_H  in  4  one-hot block selects from the SRAM block decoder.
- SRam_CE_L  out  4  per-block chip enables.
- SRam_OE_L  out  1  output enable.
- SRam_WE_L  out  1  write enable.
- SRam_UB_L  out  1  upper byte enable.
- SRam_LB_L  out  1  lower byte enable.
- Dtack_L  out  1  data transfer acknowledge to the CPU.
- Busy_H  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-high.
  - All outputs are registered.
  - Reset values: SRam_CE_L=4'hF; SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, Dtack_L = 1; Busy_H=0; state=IDLE; counter=0.
- States: IDLE, SETUP, ACCESS, ACK.
- IDLE:
  - Leave when AS_L=0 and SRamSelect_H=1 and Block_H!=0.
  - On leaving, latch Block_H, RW, UDS_L and LDS_L, then go to SETUP.
- SETUP (exactly 1 cycle):
  - CE_L = ~latched Block_H.
  - UB_L / LB_L = latched UDS_L / LDS_L.
  - OE_L=0 if read.
  - WE_L stays 1.
  - Counter loads WAIT_STATES. Go to ACCESS.
- ACCESS:
  - WE_L=0 if write; OE_L=0 if read.
  - If counter==0, go to ACK; otherwise decrement.
  - ACCESS therefore lasts WAIT_STATES+1 cycles.
- ACK:
  - Dtack_L=0 and WE_L=1 (write hold: CE stays low for at least one cycle after WE rises).
  - CE, OE and byte enables are held.
  - Stay until AS_L=1, then go to IDLE with all outputs inactive on the next edge.
- Latency: AS_L low sampled at edge n gives Dtack_L low after edge n+3+WAIT_STATES. With the default, that is edge n+5.
- Abort: AS_L=1 sampled in SETUP or ACCESS goes to IDLE immediately. Dtack_L is never asserted and all outputs are inactive.
- Back-to-back cycles: AS_L must be seen high for at least one edge in ACK before a new cycle starts.
  - AS_L held low across cycles does not retrigger.
  - A new cycle can start from IDLE on the edge after the return to IDLE.
- Mid-cycle input changes: Block_H, RW and strobe changes after the latch point are ignored.
- SRamSelect_H=1 with Block_H=0: no cycle starts; all outputs stay inactive.
- Reset mid-cycle: all outputs go inactive immediately (asynchronously).

Optional Feature:
- Macro: SRAM_ONEHOT_CHECK_EN.
- Defined:
  - Adds output BusErr_L (1 bit, reset 1).
  - At the IDLE latch point, if Block_H is non-zero and not one-hot, go to ACK with CE_L=4'hF, Dtack_L=1 and BusErr_L=0.
  - Hold there until AS_L=1.
- Undefined:
  - No BusErr_L port.
  - A non-one-hot Block_H drives every selected CE_L low; no check is made.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, ACK),
  - NUM_BLOCKS=4,
  - the default WAIT_STATES constant.
- One natural sub-module: sram_wait_counter, a loadable down-counter with a zero flag.

Test Plan:
- Read, WAIT_STATES=2, Block_H=4'b0100, UDS_L=LDS_L=0, AS_L low sampled at edge 10:
  - CE_L=4'b1011 and OE_L=0 from edge 11.
  - Dtack_L=0 after edge 15.
  - AS_L high at edge 17 returns all outputs inactive after edge 18.
- Write, WAIT_STATES=2, Block_H=4'b0001, LDS_L=0, UDS_L=1:
  - WE_L=0 for exactly 3 cycles.
  - LB_L=0, UB_L=1.
  - WE_L=1 while CE_L[0]=0 in ACK.
- Abort: AS_L rises during ACCESS:
  - Dtack_L stays 1.
  - All outputs inactive on the next edge.
  - Busy_H=0.
- SRamSelect_H=0, or Block_H=4'b0000, with AS_L=0 held for 20 cycles: all outputs stay inactive and Busy_H=0.
- Reset_H pulsed asynchronously mid-ACCESS of a write: WE_L and CE_L go to 1 before the next clock edge; state is IDLE.
- With SRAM_ONEHOT_CHECK_EN defined, Block_H=4'b0011: BusErr_L=0, CE_L=4'hF and Dtack_L=1 until AS_L=1.
